// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the system-bus arbiter: ownership state encodings,
// also driven out on the owner debug port.
package bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_CPU    = 2'b00,
        ARB_TURN_D = 2'b01,
        ARB_DMA    = 2'b10,
        ARB_TURN_C = 2'b11
    } arb_state_e;

endpackage

// File: rtl/bus_arbiter.sv
// CPU/DMA arbiter for the memory-map bus: parks on the CPU, gives DMA priority with
// a bounded burst when the CPU waits, and inserts a dead cycle on every handover.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int BURST_MAX = 4,
    parameter int CNT_W     = 3
) (
    input  logic        MCLK,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic [15:0] cpu_MAB,
    input  logic [15:0] cpu_MDBwrite,
    input  logic        cpu_MW,
    input  logic        cpu_BW,
    output logic        cpu_hold,
    input  logic        dma_req,
    input  logic        dma_lock,
    input  logic [15:0] dma_MAB,
    input  logic [15:0] dma_MDBwrite,
    input  logic        dma_MW,
    input  logic        dma_BW,
    output logic        dma_gnt,
    output logic [15:0] MAB,
    output logic [15:0] MDBwrite,
    output logic        MW,
    output logic        BW,
    output logic [1:0]  owner
);

    // With BURST_MAX == 0 the cap is never reached and the counter idles at zero.
    localparam logic [CNT_W-1:0] CNT_CAP = (BURST_MAX == 0) ? '0 : CNT_W'(BURST_MAX - 1);
    localparam bit               LIMITED = (BURST_MAX != 0);

    arb_state_e       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             at_cap;

    // NOTE: state is updated with non-blocking assignments only; reset is synchronous,
    // so rst is just another condition sampled at the clock edge.
    always_ff @(posedge MCLK) begin
        if (rst) begin
            state <= ARB_CPU;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    assign at_cap = LIMITED && (cnt == CNT_CAP);

    // NOTE: every combinational output gets a default before the case, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            ARB_CPU:    if (dma_req) state_nxt = ARB_TURN_D;
            ARB_TURN_D: begin
                state_nxt = dma_req ? ARB_DMA : ARB_CPU;
                cnt_nxt   = '0;
            end
            ARB_DMA: begin
                if (!dma_req) begin
                    state_nxt = ARB_TURN_C;
                end else if (at_cap && cpu_req && !dma_lock) begin
                    state_nxt = ARB_TURN_C;
                    cnt_nxt   = '0;
                end else if (cnt != CNT_CAP) begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ARB_TURN_C: state_nxt = ARB_CPU;
        endcase
    end

    // Zero-latency bus mux; turnaround states drive an idle, all-zero bus.
    always_comb begin
        MAB      = '0;
        MDBwrite = '0;
        MW       = 1'b0;
        BW       = 1'b0;
        cpu_hold = 1'b0;
        dma_gnt  = 1'b0;
        unique case (state)
            ARB_CPU: begin
                MAB      = cpu_MAB;
                MDBwrite = cpu_MDBwrite;
                MW       = cpu_MW;
                BW       = cpu_BW;
            end
            ARB_DMA: begin
                MAB      = dma_MAB;
                MDBwrite = dma_MDBwrite;
                MW       = dma_MW & dma_req;
                BW       = dma_BW & dma_req;
                dma_gnt  = 1'b1;
                cpu_hold = cpu_req;
            end
            ARB_TURN_D, ARB_TURN_C: cpu_hold = cpu_req;
        endcase
        // No write strobe may reach memory in a reset cycle, whatever the state.
        if (rst) begin
            MW       = 1'b0;
            BW       = 1'b0;
            cpu_hold = 1'b0;
            dma_gnt  = 1'b0;
        end
    end

    assign owner = state;

    a_single_owner: assert property (@(posedge MCLK) disable iff (rst)
        !(dma_gnt && !cpu_hold && cpu_req));

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter: reset, single word, burst fairness,
// lock, abandoned request and reset in the middle of a burst.
module tb_bus_arbiter;

    logic        MCLK = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_MW, cpu_BW, cpu_hold;
    logic [15:0] cpu_MAB, cpu_MDBwrite;
    logic        dma_req, dma_lock, dma_MW, dma_BW, dma_gnt;
    logic [15:0] dma_MAB, dma_MDBwrite;
    logic [15:0] MAB, MDBwrite;
    logic        MW, BW;
    logic [1:0]  owner;

    int errors = 0;
    int checks = 0;

    always #5 MCLK = ~MCLK;

    bus_arbiter #(.BURST_MAX(4), .CNT_W(3)) dut (
        .MCLK(MCLK), .rst(rst),
        .cpu_req(cpu_req), .cpu_MAB(cpu_MAB), .cpu_MDBwrite(cpu_MDBwrite),
        .cpu_MW(cpu_MW), .cpu_BW(cpu_BW), .cpu_hold(cpu_hold),
        .dma_req(dma_req), .dma_lock(dma_lock), .dma_MAB(dma_MAB),
        .dma_MDBwrite(dma_MDBwrite), .dma_MW(dma_MW), .dma_BW(dma_BW),
        .dma_gnt(dma_gnt), .MAB(MAB), .MDBwrite(MDBwrite), .MW(MW), .BW(BW),
        .owner(owner)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
    task automatic next_cycle();
        @(posedge MCLK);
        #1;
    endtask

    task automatic clear_inputs();
        cpu_req = 0; cpu_MAB = '0; cpu_MDBwrite = '0; cpu_MW = 0; cpu_BW = 0;
        dma_req = 0; dma_lock = 0; dma_MAB = '0; dma_MDBwrite = '0; dma_MW = 0; dma_BW = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        clear_inputs();
        next_cycle();
        next_cycle();
        rst = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int gnt_cnt;
        int hold_cnt;
        logic [1:0] seq_fair [14] = '{2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd3, 2'd0,
                                      2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd3, 2'd0};
        logic [1:0] seq_lock [9]  = '{2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd3, 2'd0};
        logic [1:0] seq_word [5]  = '{2'd1, 2'd2, 2'd2, 2'd3, 2'd0};

        // 1: reset with an active CPU write pending
        clear_inputs();
        rst = 1; cpu_req = 1; cpu_MAB = 16'hC000; cpu_MW = 1;
        next_cycle();
        check("rst_mw_c1", MW, 0);
        check("rst_gnt", dma_gnt, 0);
        check("rst_hold", cpu_hold, 0);
        check("rst_owner", owner, 2'b00);
        next_cycle();
        check("rst_mw_c2", MW, 0);
        rst = 0;
        #1;
        check("post_rst_owner", owner, 2'b00);
        check("post_rst_mab", MAB, 16'hC000);
        check("post_rst_mw", MW, 1);
        check("post_rst_hold", cpu_hold, 0);
        check("post_rst_gnt", dma_gnt, 0);
        check("post_rst_cnt", dut.cnt, 0);

        // 2: single DMA word; the requester drops dma_req once it has seen a granted
        // cycle, so the DMA state lasts one extra, strobe-free cycle before TURN_C.
        dma_req = 1; dma_MAB = 16'h0200; dma_MDBwrite = 16'hBEEF; dma_MW = 1;
        #1;
        check("word_c0_owner", owner, 2'b00);
        hold_cnt = 0;
        for (int c = 0; c < 5; c++) begin
            next_cycle();
            if (c == 2) dma_req = 0;
            #1;
            check($sformatf("word_c%0d_owner", c + 1), owner, seq_word[c]);
            if (cpu_hold) hold_cnt++;
            if (c == 0) begin
                check("word_turn_mw", MW, 0);
                check("word_turn_mab", MAB, 16'h0000);
                check("word_turn_hold", cpu_hold, 1);
            end
            if (c == 1) begin
                check("word_dma_mab", MAB, 16'h0200);
                check("word_dma_mdb", MDBwrite, 16'hBEEF);
                check("word_dma_mw", MW, 1);
                check("word_dma_gnt", dma_gnt, 1);
            end
            if (c == 2) check("word_idle_mw", MW, 0);
        end
        check("word_hold_cycles", hold_cnt, 4);

        // 3: fairness with both requesters held
        do_reset();
        cpu_req = 1; dma_req = 1; dma_MW = 1;
        gnt_cnt = 0;
        for (int c = 0; c < 14; c++) begin
            next_cycle();
            check($sformatf("fair_c%0d_owner", c + 1), owner, seq_fair[c]);
            if (dma_gnt) gnt_cnt++;
        end
        check("fair_gnt_total", gnt_cnt, 8);

        // 4: lock across the cap; lock drops during the sixth DMA word
        do_reset();
        cpu_req = 1; dma_req = 1; dma_lock = 1;
        gnt_cnt = 0;
        for (int c = 0; c < 9; c++) begin
            next_cycle();
            if (c == 6) dma_lock = 0;
            #1;
            check($sformatf("lock_c%0d_owner", c + 1), owner, seq_lock[c]);
            check($sformatf("lock_c%0d_cnt_le3", c + 1), (dut.cnt <= 3), 1);
            if (c == 6) check("lock_cnt_sat", dut.cnt, 3);
            if (dma_gnt) gnt_cnt++;
        end
        check("lock_gnt_total", gnt_cnt, 6);

        // 5: DMA abandons its request during the turnaround
        do_reset();
        dma_req = 1;
        next_cycle();
        dma_req = 0;
        #1;
        check("aband_turn_owner", owner, 2'b01);
        check("aband_turn_gnt", dma_gnt, 0);
        next_cycle();
        check("aband_owner", owner, 2'b00);
        check("aband_gnt", dma_gnt, 0);
        next_cycle();
        check("aband_stay_owner", owner, 2'b00);

        // 6: reset on the second DMA cycle, then a fresh full burst
        do_reset();
        dma_req = 1; dma_MW = 1; dma_MAB = 16'h0300;
        next_cycle();
        next_cycle();
        check("rmid_dma1_mw", MW, 1);
        next_cycle();
        rst = 1;
        #1;
        check("rmid_mw", MW, 0);
        check("rmid_gnt", dma_gnt, 0);
        next_cycle();
        rst = 0; cpu_req = 1;
        #1;
        check("rmid_owner", owner, 2'b00);
        check("rmid_cnt", dut.cnt, 0);
        check("rmid_gnt_after", dma_gnt, 0);
        gnt_cnt = 0;
        for (int c = 0; c < 7; c++) begin
            next_cycle();
            check($sformatf("rmid_c%0d_owner", c + 1), owner, seq_fair[c]);
            if (dma_gnt) gnt_cnt++;
        end
        check("rmid_burst_gnt", gnt_cnt, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
